adc_capture: RTL
================

Name: adc_capture

Overview:
- Conversion controller for the board's dual-channel SAR ADC; sits between the host-command sequencer and the ADC pins (CNVST_ADC, BUSY_ADC, CS_ADC, SCLK_ADC, DOUTA_ADC, DOUTB_ADC).
- On a start pulse: fires a conversion, waits out BUSY, then serially reads both channels in parallel.
- Presents two DATA_W-bit results with a one-cycle valid strobe to the readout FIFO / pipe-out logic.

Parameters:
- DATA_W, 12: bits per channel shifted out of DOUTA/DOUTB, MSB first.
- CNV_LOW, 3: CLK cycles CNVST_ADC is held low to start a conversion (min 1).
- SCLK_DIV, 4: CLK cycles per SCLK half-period (min 1); with 100 MHz CLK the default SCLK is 12.5 MHz.
- CS_SETUP, 2: CLK cycles from CS_ADC falling to the first SCLK falling edge.
- BUSY_TMO, 255: CLK cycles allowed in each BUSY wait before abort. Used only with ADC_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only when ready=1, ignored otherwise.
- ready  output  1  high in IDLE.
- CNVST_ADC  output  1  conversion start, active low.
- BUSY_ADC  input  1  ADC busy, asynchronous; two-flop synchronised internally.
- CS_ADC  output  1  serial chip select, active low.
- SCLK_ADC  output  1  serial clock, idles high.
- DOUTA_ADC  input  1  channel A serial data.
- DOUTB_ADC  input  1  channel B serial data.
- data_a  output  DATA_W  channel A result.
- data_b  output  DATA_W  channel B result.
- valid  output  1  one-cycle strobe; data_a/data_b are updated on the same cycle.
- busy_err  output  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, ready=1.
  - CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1.
  - data_a=0, data_b=0, valid=0, busy_err=0.
  - Synchroniser flops=0.
  - Reset mid-transfer forces these values immediately; no partial result is emitted.
- All outputs are registered. BUSY_ADC is used only as busy_s, its synchronised copy (2-cycle latency).
- IDLE:
  - start=1 -> CONV.
  - ready drops on the next edge.
  - CNVST_ADC is driven low on the same edge.
- CONV: CNVST_ADC low for exactly CNV_LOW cycles, then high -> WAIT_HI.
- WAIT_HI: wait for busy_s=1 -> WAIT_LO.
- WAIT_LO: wait for busy_s=0 -> SETUP. CS_ADC goes low on that edge.
- SETUP: hold CS_ADC low for CS_SETUP cycles -> SHIFT.
- SHIFT:
  - SCLK_ADC toggles every SCLK_DIV cycles, starting with a falling edge.
  - On each CLK edge that drives SCLK_ADC 1->0, the current DOUTA_ADC and DOUTB_ADC are shifted into two shift registers (left shift, LSB in). The MSB is therefore the value presented before the first falling edge.
  - A bit counter counts DATA_W falling edges.
  - After the DATA_W-th sample, SCLK_ADC returns high after one half-period -> DONE.
- DONE (1 cycle):
  - CS_ADC=1.
  - data_a/data_b load the shift registers; valid=1.
  - -> IDLE; ready=1 on the next cycle.
- The capture sequence itself is not pipelined: a start while ready=0 is dropped.
- Busy pulse edge cases:
  - A busy_s pulse shorter than the synchroniser window may be missed. Without timeout the FSM then waits in WAIT_HI indefinitely; the sequencer must reset.
  - A busy_s already high on entry to WAIT_HI is accepted immediately.
- Nominal latency, start to valid:
  - Timing components: CNV_LOW + busy rise + 2 + busy width + 2 + CS_SETUP + 2*SCLK_DIV*DATA_W + 1 cycles.
  - With defaults and a 74-cycle busy: about 3+4+2+70+2+2+96+1 = 180 cycles.

Optional Feature:
- Macro: ADC_TIMEOUT_EN.
- Defined:
  - A down-counter loads BUSY_TMO on entry to WAIT_HI and again on entry to WAIT_LO.
  - Reaching 0 in either state sets busy_err=1 and returns to IDLE with CS_ADC=1 and SCLK_ADC=1.
  - No valid strobe is issued; data_a/data_b are unchanged.
- Undefined:
  - The counter logic is absent and busy_err is tied to 0.
  - The WAIT states block indefinitely.

Test Plan:
- Reset, then start; the ADC model asserts BUSY 40 ns after CNVST falls and holds it 700 ns. DOUTA streams 0xA5C and DOUTB streams 0x3F1, each bit changing 20 ns after SCLK falls. -> Exactly one valid pulse; data_a=0xA5C, data_b=0x3F1; exactly 12 SCLK falling edges while CS_ADC=0; CNVST_ADC low for 30 ns.
- Second start pulse during SHIFT of a conversion. -> Ignored; one valid only; a fresh start after ready=1 gives a correct second result (DOUTA=0xFFF, DOUTB=0x000).
- RST_N asserted at the 6th SCLK falling edge. -> All outputs return to reset values within the same time step; no valid; the next full conversion returns correct data.
- ADC_TIMEOUT_EN defined, BUSY_ADC held 0. -> After about BUSY_TMO+1 cycles: busy_err=1, ready=1, valid never asserted; the next start clears busy_err.
- ADC_TIMEOUT_EN defined, BUSY_ADC stuck 1. -> Timeout from WAIT_LO, busy_err=1, CS_ADC stays 1 throughout.
- Back-to-back: start asserted on the first cycle ready=1, repeated 4 times with random DOUT data. -> 4 valids; each result matches the model's shifted words.

Source files
------------

// File: rtl/adc_capture.sv
`timescale 1ns/1ps
// adc_capture: conversion controller for a dual-channel SAR ADC.
// Fires CNVST, waits out BUSY, then clocks both serial channels in parallel
// and presents the two results with a one-cycle valid strobe.
// Optional BUSY-wait timeout enabled by defining ADC_TIMEOUT_EN.
module adc_capture #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned CNV_LOW  = 3,
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned BUSY_TMO = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              ready,
  output logic              CNVST_ADC,
  input  logic              BUSY_ADC,
  output logic              CS_ADC,
  output logic              SCLK_ADC,
  input  logic              DOUTA_ADC,
  input  logic              DOUTB_ADC,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              valid,
  output logic              busy_err
);

  localparam int unsigned CNT_MAX_A = (CNV_LOW > CS_SETUP) ? CNV_LOW : CS_SETUP;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > SCLK_DIV) ? CNT_MAX_A : SCLK_DIV;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W     = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_cnvst;
  logic                r_cs;
  logic                r_sclk;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data_a;
  logic [DATA_W-1:0]   r_data_b;
  logic [DATA_W-1:0]   r_sr_a;
  logic [DATA_W-1:0]   r_sr_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_busy_m;
  logic                r_busy_s;
  logic                w_busy_s;

`ifdef ADC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);
  logic [TMO_W-1:0]    r_tmo;
  logic                r_busy_err;
  assign busy_err = r_busy_err;
`else
  logic                w_unused_tmo;
  assign w_unused_tmo = |BUSY_TMO;
  assign busy_err     = 1'b0;
`endif

  assign w_busy_s  = r_busy_s;
  assign ready     = r_ready;
  assign CNVST_ADC = r_cnvst;
  assign CS_ADC    = r_cs;
  assign SCLK_ADC  = r_sclk;
  assign valid     = r_valid;
  assign data_a    = r_data_a;
  assign data_b    = r_data_b;

  // Two-flop synchroniser for the asynchronous BUSY pin.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
    end else begin
      r_busy_m <= BUSY_ADC;
      r_busy_s <= r_busy_m;
    end
  end

  // Capture sequencer: conversion strobe, BUSY handshake, serial readout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_cnvst    <= 1'b1;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b1;
      r_valid    <= 1'b0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_sr_a     <= '0;
      r_sr_b     <= '0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
`ifdef ADC_TIMEOUT_EN
      r_tmo      <= '0;
      r_busy_err <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CONV;
            r_ready   <= 1'b0;
            r_cnvst   <= 1'b0;
            r_cnt     <= CNT_W'(CNV_LOW - 1);
            r_bit_cnt <= '0;
`ifdef ADC_TIMEOUT_EN
            r_busy_err <= 1'b0;
`endif
          end
        end

        S_CONV: begin
          if (r_cnt == '0) begin
            r_cnvst <= 1'b1;
            r_state <= S_WAIT_HI;
`ifdef ADC_TIMEOUT_EN
            r_tmo   <= TMO_W'(BUSY_TMO);
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_WAIT_HI: begin
          if (w_busy_s) begin
            r_state <= S_WAIT_LO;
`ifdef ADC_TIMEOUT_EN
            r_tmo   <= TMO_W'(BUSY_TMO);
`endif
          end
`ifdef ADC_TIMEOUT_EN
          else if (r_tmo == '0) begin
            r_busy_err <= 1'b1;
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
`endif
        end

        S_WAIT_LO: begin
          if (!w_busy_s) begin
            r_state <= S_SETUP;
            r_cs    <= 1'b0;
            r_cnt   <= CNT_W'(CS_SETUP - 1);
          end
`ifdef ADC_TIMEOUT_EN
          else if (r_tmo == '0) begin
            r_busy_err <= 1'b1;
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
          end
`endif
        end

        // The exit edge of SETUP is the first SCLK falling edge.
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state   <= S_SHIFT;
            r_sclk    <= 1'b0;
            r_sr_a    <= {r_sr_a[DATA_W-2:0], DOUTA_ADC};
            r_sr_b    <= {r_sr_b[DATA_W-2:0], DOUTB_ADC};
            r_bit_cnt <= BIT_W'(1);
            r_cnt     <= CNT_W'(SCLK_DIV - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        // Sample on every falling edge; the final rising edge closes the frame.
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_cnt <= CNT_W'(SCLK_DIV - 1);
            if (r_sclk) begin
              r_sclk    <= 1'b0;
              r_sr_a    <= {r_sr_a[DATA_W-2:0], DOUTA_ADC};
              r_sr_b    <= {r_sr_b[DATA_W-2:0], DOUTB_ADC};
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else if (r_bit_cnt == BIT_W'(DATA_W)) begin
              r_sclk   <= 1'b1;
              r_cs     <= 1'b1;
              r_data_a <= r_sr_a;
              r_data_b <= r_sr_b;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_sclk <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_cnvst <= 1'b1;
          r_cs    <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

endmodule
